// File: rtl/ppt_measure_controller.sv
// Sequences one pulse-generate / pulse-count measurement: shadows the configuration,
// clears the counter, gates generator and counter for the window, drains, then latches.
module ppt_measure_controller #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] cfg_period,
  input  logic [15:0] cfg_width,
  input  logic [15:0] cfg_window,
  input  logic [15:0] count_in,
  output logic [15:0] gen_period,
  output logic [15:0] gen_width,
  output logic        gen_run,
  output logic        cnt_run,
  output logic        cnt_clear,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        done,
  output logic        busy,
  output logic        cfg_err,
  output logic        ovf
);

  // Handshake: start is a level request sampled only in IDLE; abort wins over start
  // and cancels any active measurement; done is a single-cycle completion pulse.
  typedef enum logic [1:0] {IDLE, ARM, RUN, SETTLE} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t      state_q, state_d;
  logic [15:0] period_q, width_q, window_q;
  logic [15:0] win_cnt_q;
  logic [3:0]  settle_cnt_q;
  logic        cfg_legal, req, accept, reject, win_last, settle_last, finish;

  assign cfg_legal   = (cfg_period != 16'd0) && (cfg_width != 16'd0) &&
                       (cfg_width < cfg_period) && (cfg_window != 16'd0);
  assign req         = (state_q == IDLE) && start && !abort;
  assign accept      = req && cfg_legal;
  assign reject      = req && !cfg_legal;
  assign win_last    = (win_cnt_q == 16'd1);
  assign settle_last = (settle_cnt_q == 4'd1);
  assign finish      = (state_q == SETTLE) && !abort && settle_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ARM;
      ARM:     state_d = abort ? IDLE : RUN;
      RUN:     if (abort) state_d = IDLE;
               else if (win_last) state_d = SETTLE;
      SETTLE:  if (abort || settle_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore decode only: none of these see an input combinationally.
  assign busy      = (state_q != IDLE);
  assign cnt_clear = (state_q == ARM);
  assign gen_run   = (state_q == RUN);
  assign cnt_run   = (state_q == RUN) || (state_q == SETTLE);

  assign gen_period = period_q;
  assign gen_width  = width_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q     <= 16'd0;
      width_q      <= 16'd0;
      window_q     <= 16'd0;
      win_cnt_q    <= 16'd0;
      settle_cnt_q <= 4'd0;
      result       <= 16'd0;
      result_valid <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        period_q     <= cfg_period;
        width_q      <= cfg_width;
        window_q     <= cfg_window;
        cfg_err      <= 1'b0;
        result_valid <= 1'b0;
        ovf          <= 1'b0;
      end else if (reject) begin
        cfg_err <= 1'b1;
      end
      // Window counter is loaded in ARM and stops at 1, so it never wraps.
      if (state_q == ARM)                  win_cnt_q <= window_q;
      else if (state_q == RUN && !win_last) win_cnt_q <= win_cnt_q - 16'd1;
      if (state_q == RUN)         settle_cnt_q <= SETTLE_INIT;
      else if (state_q == SETTLE) settle_cnt_q <= settle_cnt_q - 4'd1;
      if (finish) begin
        result       <= count_in;
        result_valid <= 1'b1;
        ovf          <= (count_in == 16'hFFFF);
      end
    end
  end

endmodule

// File: doc/ppt_measure_controller.md
PPT_MEASURE_CONTROLLER -- requirements
Module: ppt_measure_controller

Purpose: sequences one pulse-generate/pulse-count measurement: configures the generator, clears and gates the counter for a programmed window, latches the result, and reports completion.

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2: counter drain cycles after the generator stops, legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1: the only clock, which is the divided system clock.
REQ-003 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1: level-sampled request for one measurement.
REQ-005 The block SHALL have port abort, input, 1: cancels the measurement in progress.
REQ-006 The block SHALL have ports cfg_period, cfg_width and cfg_window, each input, 16: generator period, generator pulse width and window length in clk cycles.
REQ-007 The block SHALL have port count_in, input, 16: the live count from the pulse counter.
REQ-008 The block SHALL have ports gen_period and gen_width, each output, 16: shadowed configuration driven to the generator.
REQ-009 The block SHALL have ports gen_run, cnt_run and cnt_clear, each output, 1: generator enable, counter enable and synchronous counter clear.
REQ-010 The block SHALL have port result, output, 16: the latched count.
REQ-011 The block SHALL have ports result_valid, done, busy, cfg_err and ovf, each output, 1: result valid, completion pulse, busy, configuration error and overflow.

Function
REQ-012 The state machine SHALL have exactly four states: IDLE, ARM, RUN and SETTLE.
REQ-013 busy SHALL be 1 in every state other than IDLE.
REQ-014 start SHALL be sampled only in IDLE and SHALL be ignored in every other state.
REQ-015 On start in IDLE, the block SHALL capture cfg_period, cfg_width and cfg_window into shadow registers; the gen_period and gen_width outputs SHALL be driven from the shadow registers.
REQ-016 A configuration SHALL be illegal when any of these holds: cfg_period==0, cfg_width==0, cfg_width>=cfg_period, cfg_window==0.
REQ-017 On an illegal configuration, cfg_err SHALL be set to 1, the state SHALL remain IDLE, the shadow registers SHALL not be updated, and result and result_valid SHALL be unchanged.
REQ-018 On a legal configuration, the next state SHALL be ARM, and cfg_err, result_valid and ovf SHALL clear to 0.
REQ-019 In ARM, the block SHALL drive cnt_clear=1, gen_run=0 and cnt_run=0 for exactly 1 cycle, then go to RUN.
REQ-020 In RUN, the block SHALL drive gen_run=1 and cnt_run=1 for exactly cfg_window cycles, timed by a 16-bit down-counter loaded from the shadowed window; then it SHALL go to SETTLE.
REQ-021 In SETTLE, the block SHALL drive gen_run=0 and cnt_run=1 for exactly SETTLE_CYCLES cycles.
REQ-022 On the clock edge that ends SETTLE, the block SHALL set result<=count_in, result_valid<=1, ovf<=(count_in==16'hFFFF) and done<=1, and the state SHALL return to IDLE.
REQ-023 done SHALL be high for exactly 1 cycle per completed measurement.
REQ-024 Latency SHALL be fixed: done SHALL be high in the cycle beginning cfg_window+SETTLE_CYCLES+1 edges after the edge that sampled start.
REQ-025 result_valid SHALL stay high until the next legal start or reset.
REQ-026 A start asserted in the same cycle that done is high SHALL be accepted as a new measurement.
REQ-027 When abort=1 in ARM, RUN or SETTLE, the next state SHALL be IDLE with gen_run, cnt_run and cnt_clear deasserted, no done pulse, and result, result_valid and ovf unchanged.
REQ-028 When abort and start are both 1 in IDLE, abort SHALL take priority and start SHALL be ignored.
REQ-029 gen_run, cnt_run, cnt_clear and busy SHALL be Moore outputs decoded from the state register, with no combinational path from any input.
REQ-030 The window down-counter SHALL never wrap; cfg_window=16'hFFFF SHALL give exactly 65535 RUN cycles.

Reset
REQ-031 While rst_n=0, the block SHALL asynchronously force state=IDLE.
REQ-032 While rst_n=0, the block SHALL force the shadow registers, window counter and result to 0.
REQ-033 While rst_n=0, the block SHALL force result_valid, done, busy, cfg_err, ovf, gen_run, cnt_run and cnt_clear to 0.
REQ-034 After rst_n is released, the first start SHALL be accepted on the first clk edge at which it is sampled.
REQ-035 When reset is asserted mid-measurement, the measurement SHALL be discarded and no done pulse SHALL be produced.

Verification
REQ-036 The bench SHALL cover nominal operation: period=10, width=2, window=10, SETTLE_CYCLES=2, count_in model = 1 per generator pulse; required response: cnt_clear for 1 cycle, then gen_run for 10 cycles, done in the 13th cycle after start, result=1, result_valid=1, ovf=0.
REQ-037 The bench SHALL cover illegal configuration: width=10 with period=10; required response: cfg_err=1, busy stays 0, gen_run never asserted, previous result retained.
REQ-038 The bench SHALL cover abort: abort asserted in RUN cycle 5; required response: busy=0 on the next cycle, gen_run and cnt_run low, no done pulse, result_valid unchanged.
REQ-039 The bench SHALL cover back-to-back operation: start held high continuously with window=4; required response: done every 8 cycles (4+2+1 busy cycles plus 1 IDLE cycle), each done accompanied by a fresh cnt_clear.
REQ-040 The bench SHALL cover overflow: count_in forced to 16'hFFFF during SETTLE; required response: result=16'hFFFF, ovf=1, then ovf=0 after the next legal start.
REQ-041 The bench SHALL cover reset during SETTLE: rst_n pulsed low during SETTLE; required response: all outputs 0 immediately, no done pulse, and the next start completes normally.
